// File: rtl/pipelined_control_unit_if.sv
// Decode/control pipeline bus: ID-side inputs, stall feedback and per-stage control outputs.
// The master drives ID/flush/stall; the slave is the control unit.
interface pipelined_control_unit_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
);
  localparam int CTRL_W = 8 + ALUOP_W;

  logic              id_valid;
  logic [31:0]       id_instr;
  logic              flush;
  logic              ext_stall;
  logic              hazard_stall;
  logic              ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;

  modport master (
    output id_valid, id_instr, flush, ext_stall,
    input  hazard_stall, ex_valid, mem_valid, wb_valid,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd
  );

  modport slave (
    input  id_valid, id_instr, flush, ext_stall,
    output hazard_stall, ex_valid, mem_valid, wb_valid,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32 decode-and-control pipeline: ID decode into EX/MEM/WB control registers with load-use bubbles.
// Optional CTRL_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipelined_control_unit #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_control_unit_if.slave bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);
  localparam int CTRL_W = 8 + ALUOP_W;
  localparam int STAGES = 3;

  localparam int RW = 0, MR = 1, MW = 2, AS = 3, BR = 4, MTR = 5, JMP = 6, LNK = 7;
  localparam int ALU_ADD = 0, ALU_BRCMP = 1, ALU_RFUNCT = 2, ALU_IFUNCT = 3, ALU_LUI = 4, ALU_AUIPC = 5;

  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_IA = 7'b0010011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
  } word_t;

  // Index 1 = EX, 2 = MEM, 3 = WB.
  logic  [STAGES:1] vld_pipe;
  word_t [STAGES:1] wrd_pipe;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_ok, use_rs1, use_rs2;
  logic              ex_load, hz_cond, hz_stall, bubble;
  logic              nxt_vld;
  word_t             nxt_wrd;
  logic              unused_instr;

  assign opcode       = bus.id_instr[6:0];
  assign rs1          = bus.id_instr[15 +: REG_AW];
  assign rs2          = bus.id_instr[20 +: REG_AW];
  assign unused_instr = ^bus.id_instr;

  always_comb begin
    dec_ctrl = '0;
    dec_ok   = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctrl[RW] = 1'b1; dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_RFUNCT);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_LD: begin
        dec_ctrl[RW] = 1'b1; dec_ctrl[MR] = 1'b1; dec_ctrl[AS] = 1'b1; dec_ctrl[MTR] = 1'b1;
        dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_ADD);
        use_rs1 = 1'b1;
      end
      OP_ST: begin
        dec_ctrl[MW] = 1'b1; dec_ctrl[AS] = 1'b1; dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_ADD);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BR: begin
        dec_ctrl[BR] = 1'b1; dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_BRCMP);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_IA: begin
        dec_ctrl[RW] = 1'b1; dec_ctrl[AS] = 1'b1; dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_IFUNCT);
        use_rs1 = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec_ctrl[RW] = 1'b1; dec_ctrl[AS] = 1'b1; dec_ctrl[JMP] = 1'b1; dec_ctrl[LNK] = 1'b1;
        dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_ADD);
        use_rs1 = (opcode == OP_JALR);
      end
      OP_LUI: begin
        dec_ctrl[RW] = 1'b1; dec_ctrl[AS] = 1'b1; dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_LUI);
      end
      OP_AUIPC: begin
        dec_ctrl[RW] = 1'b1; dec_ctrl[AS] = 1'b1; dec_ctrl[8 +: ALUOP_W] = ALUOP_W'(ALU_AUIPC);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Hazard only against a load in EX that really writes a non-zero register.
  assign ex_load  = vld_pipe[1] & wrd_pipe[1].ctrl[MR] & (wrd_pipe[1].rd != '0);
  assign hz_cond  = bus.id_valid & ex_load &
                    ((use_rs1 & (rs1 == wrd_pipe[1].rd)) | (use_rs2 & (rs2 == wrd_pipe[1].rd)));
  assign hz_stall = hz_cond & ~bus.flush;
  assign bubble   = ~bus.id_valid | ~dec_ok | bus.flush | hz_cond;

  assign nxt_vld      = ~bubble;
  assign nxt_wrd.ctrl = bubble ? '0 : dec_ctrl;
  assign nxt_wrd.rd   = (bubble | ~dec_ctrl[RW]) ? '0 : bus.id_instr[7 +: REG_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      wrd_pipe <= '0;
    end else if (!bus.ext_stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], nxt_vld};
      wrd_pipe <= {wrd_pipe[STAGES-1:1], nxt_wrd};
    end
  end

  assign bus.hazard_stall = hz_stall;
  assign bus.ex_valid     = vld_pipe[1];
  assign bus.mem_valid    = vld_pipe[2];
  assign bus.wb_valid     = vld_pipe[3];
  assign bus.ex_ctrl      = wrd_pipe[1].ctrl;
  assign bus.mem_ctrl     = wrd_pipe[2].ctrl;
  assign bus.wb_ctrl      = wrd_pipe[3].ctrl;
  assign bus.ex_rd        = wrd_pipe[1].rd;
  assign bus.mem_rd       = wrd_pipe[2].rd;
  assign bus.wb_rd        = wrd_pipe[3].rd;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (!bus.ext_stall) begin
      if (hz_stall && !(&perf_stall_cnt))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (bus.flush && !(&perf_flush_cnt))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios plus random traffic against a queue-based model.
// Build with CTRL_PERF_CNT_EN defined to also exercise the counters (CNT_W = 4).
module tb_pipelined_control_unit;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.REG_AW(5), .ALUOP_W(3)) bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [3:0] psc, pfc;
`endif

  pipelined_control_unit #(.REG_AW(5), .ALUOP_W(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CTRL_PERF_CNT_EN
    ,
    .perf_stall_cnt (psc),
    .perf_flush_cnt (pfc)
`endif
  );

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [4:0]    rd;
  } rec_t;

  rec_t mq[$];        // mq[0] = EX, mq[1] = MEM, mq[2] = WB
  int   n_cmp, n_err;
  int   m_stall, m_flush;
  bit   last_h;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic rec_t ref_decode(input logic v, input logic [31:0] ins);
    int rw = 0, mr = 0, mw = 0, as_ = 0, br = 0, mtr = 0, j = 0, l = 0, alu = 0;
    rec_t r;
    r = '0;
    case (ins[6:0])
      7'b0110011: begin rw = 1; alu = 2; end
      7'b0000011: begin rw = 1; mr = 1; as_ = 1; mtr = 1; end
      7'b0100011: begin mw = 1; as_ = 1; end
      7'b1100011: begin br = 1; alu = 1; end
      7'b0010011: begin rw = 1; as_ = 1; alu = 3; end
      7'b1101111, 7'b1100111: begin rw = 1; as_ = 1; j = 1; l = 1; end
      7'b0110111: begin rw = 1; as_ = 1; alu = 4; end
      7'b0010111: begin rw = 1; as_ = 1; alu = 5; end
      default: return '0;
    endcase
    if (!v) return '0;
    r.v  = 1'b1;
    r.c  = CW'(rw + 2*mr + 4*mw + 8*as_ + 16*br + 32*mtr + 64*j + 128*l + 256*alu);
    r.rd = (rw != 0) ? ins[11:7] : 5'd0;
    return r;
  endfunction

  function automatic bit ref_hazard(input logic v, input logic [31:0] ins);
    rec_t ex;
    bit u1, u2;
    ex = mq[0];
    u1 = ins[6:0] inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b1100111};
    u2 = ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    return v && ex.v && ex.c[1] && (ex.rd != 5'd0) &&
           ((u1 && ins[19:15] == ex.rd) || (u2 && ins[24:20] == ex.rd));
  endfunction

  function automatic logic [50:0] dut_snap();
    return {bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.mem_valid, bus.mem_ctrl, bus.mem_rd,
            bus.wb_valid, bus.wb_ctrl, bus.wb_rd};
  endfunction

  function automatic logic [50:0] exp_snap();
    return {mq[0], mq[1], mq[2]};
  endfunction

  // One clock: drive ID inputs, check the combinational stall, clock, check all stages.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic st,
                     input string tag);
    bit cond, h;
    rec_t nx;
    bus.id_valid = v; bus.id_instr = ins; bus.flush = fl; bus.ext_stall = st;
    #1;
    cond = ref_hazard(v, ins);
    h    = cond && !fl;
    n_cmp++;
    if (bus.hazard_stall !== h) begin
      n_err++;
      $display("FAIL %s hazard_stall: got %0b want %0b", tag, bus.hazard_stall, h);
    end
    @(posedge clk);
    if (!st) begin
      nx = (fl || cond) ? rec_t'('0) : ref_decode(v, ins);
      mq.push_front(nx);
      void'(mq.pop_back());
      if (h  && m_stall < 15) m_stall++;
      if (fl && m_flush < 15) m_flush++;
    end
    last_h = h;
    #1;
    n_cmp++;
    if (dut_snap() !== exp_snap()) begin
      n_err++;
      $display("FAIL %s stages: got %h want %h", tag, dut_snap(), exp_snap());
    end
`ifdef CTRL_PERF_CNT_EN
    n_cmp++;
    if (psc !== 4'(m_stall) || pfc !== 4'(m_flush)) begin
      n_err++;
      $display("FAIL %s perf: got %0d/%0d want %0d/%0d", tag, psc, pfc, m_stall, m_flush);
    end
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.id_valid = 1'b0; bus.id_instr = '0; bus.flush = 1'b0; bus.ext_stall = 1'b0;
    mq = '{rec_t'('0), rec_t'('0), rec_t'('0)};
    m_stall = 0; m_flush = 0; last_h = 0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (dut_snap() !== 51'd0 || bus.hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got %h/%0b want 0/0", dut_snap(), bus.hazard_stall);
    end
    // Mid-stream: load in EX, dependent add in ID, then drop reset between edges.
    cyc(1, mk(7'b0000011, 5, 1, 0), 0, 0, "mid_lw");
    cyc(1, mk(7'b0010011, 7, 2, 0), 0, 0, "mid_addi");
    cyc(1, mk(7'b0000011, 5, 1, 0), 0, 0, "mid_lw2");
    bus.id_instr = mk(7'b0110011, 6, 5, 2);
    #1;
    n_cmp++;
    if (bus.hazard_stall !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre_hazard: got %0b want 1", bus.hazard_stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_snap() !== 51'd0 || bus.hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got %h/%0b want 0/0", dut_snap(), bus.hazard_stall);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    cyc(1, mk(7'b0000011, 5, 1, 0), 0, 0, "lu_lw");
    cyc(1, mk(7'b0110011, 6, 5, 2), 0, 0, "lu_stall");
    n_cmp++;
    if (bus.ex_valid !== 1'b0 || bus.mem_rd !== 5'd5) begin
      n_err++;
      $display("FAIL lu_bubble: got ex_valid %0b mem_rd %0d want 0/5", bus.ex_valid, bus.mem_rd);
    end
    cyc(1, mk(7'b0110011, 6, 5, 2), 0, 0, "lu_add");
    n_cmp++;
    if (bus.ex_ctrl !== 11'h201 || bus.ex_rd !== 5'd6) begin
      n_err++;
      $display("FAIL lu_add_ctrl: got %h rd %0d want 201 rd 6", bus.ex_ctrl, bus.ex_rd);
    end
  endtask

  task automatic test_no_stall();
    cyc(1, mk(7'b0000011, 0, 1, 0), 0, 0, "ns_lw_x0");
    cyc(1, mk(7'b0110011, 6, 0, 2), 0, 0, "ns_add_x0");
    n_cmp++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin
      n_err++;
      $display("FAIL ns_x0_enter: got %0b rd %0d want 1 rd 6", bus.ex_valid, bus.ex_rd);
    end
    cyc(1, mk(7'b0000011, 5, 1, 0), 0, 0, "ns_lw_x5");
    cyc(1, mk(7'b0110111, 5, 5, 5), 0, 0, "ns_lui");
    n_cmp++;
    if (bus.ex_ctrl !== 11'h409 || bus.ex_rd !== 5'd5) begin
      n_err++;
      $display("FAIL ns_lui_ctrl: got %h rd %0d want 409 rd 5", bus.ex_ctrl, bus.ex_rd);
    end
  endtask

  task automatic test_flush();
    cyc(1, mk(7'b1100011, 0, 1, 2), 0, 0, "fl_beq");
    cyc(1, mk(7'b0010011, 7, 3, 0), 1, 0, "fl_addi");
    n_cmp++;
    if (bus.ex_valid !== 1'b0 || bus.mem_ctrl !== 11'h110) begin
      n_err++;
      $display("FAIL fl_branch: got ex_valid %0b mem_ctrl %h want 0/110", bus.ex_valid, bus.mem_ctrl);
    end
    cyc(1, mk(7'b0000011, 5, 1, 0), 0, 0, "fl_lw");
    cyc(1, mk(7'b0010011, 7, 5, 0), 1, 0, "fl_dep_addi");
  endtask

  task automatic test_ext_stall();
    cyc(1, mk(7'b0000011, 9, 1, 0), 0, 0, "es_lw");
    cyc(1, mk(7'b0110011, 6, 1, 2), 0, 0, "es_add");
    for (int i = 0; i < 3; i++) cyc(1, mk(7'b0010011, 8, 6, 0), 1, 1, "es_hold");
    n_cmp++;
    if (bus.ex_rd !== 5'd6 || bus.mem_rd !== 5'd9) begin
      n_err++;
      $display("FAIL es_frozen: got ex_rd %0d mem_rd %0d want 6/9", bus.ex_rd, bus.mem_rd);
    end
    cyc(0, 32'd0, 0, 0, "es_release");
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] ins;
    logic        v;
    ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    ins = '0; v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(last_h || bus.ext_stall)) begin
        ins = mk(ops[$urandom_range(9)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)));
        v   = ($urandom_range(7) != 0);
      end
      cyc(v, ins, ($urandom_range(7) == 0), ($urandom_range(7) == 0), "rand");
    end
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      cyc(1, mk(7'b0000011, 5, 1, 0), 0, 0, "pf_lw");
      cyc(1, mk(7'b0110011, 6, 5, 2), 0, 0, "pf_stall");
      cyc(1, mk(7'b0110011, 6, 5, 2), 0, 0, "pf_add");
    end
    cyc(0, 32'd0, 1, 0, "pf_flush");
    n_cmp++;
    if (psc !== 4'd15 || pfc !== 4'd1) begin
      n_err++;
      $display("FAIL perf_final: got %0d/%0d want 15/1", psc, pfc);
    end
  endtask
`endif

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_flush();
    test_ext_stall();
    test_random();
`ifdef CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
